// File: rtl/count_seq_arbiter_if.sv
// Bundle between the requesters, the shared counter and the sequencing arbiter.
// The slave modport is the arbiter's view; master is the requester/counter side.
interface count_seq_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4
) ();
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_load;
  logic [NREQ-1:0]        req_up_down;
  logic [NREQ*WIDTH-1:0]  req_din;
  logic [NREQ*STEP_W-1:0] req_steps;

  logic                   cnt_load;
  logic                   cnt_up_down;
  logic [WIDTH-1:0]       cnt_din;
  logic                   cnt_en;
  logic [WIDTH-1:0]       cnt_count;

  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [WIDTH-1:0]       done_count;

  modport slave (
    input  req_valid, req_load, req_up_down, req_din, req_steps, cnt_count,
    output req_ready, cnt_load, cnt_up_down, cnt_din, cnt_en,
           busy, done, done_id, done_count
  );

  modport master (
    output req_valid, req_load, req_up_down, req_din, req_steps, cnt_count,
    input  req_ready, cnt_load, cnt_up_down, cnt_din, cnt_en,
           busy, done, done_id, done_count
  );
endinterface

// File: rtl/count_seq_arbiter.sv
// Round-robin arbiter that sequences one shared up/down counter through
// optional load, N counting steps and a completion report per command.
module count_seq_arbiter #(
  parameter int NREQ   = 2,
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  count_seq_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NREQ);

  // state  | meaning
  // IDLE   | arbitrating; req_ready pulses for the winner
  // LOAD   | one cycle of cnt_load with the latched din
  // RUN    | cnt_en high for exactly the latched step count
  // DONE   | one-cycle done pulse, final count reported
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [STEP_W-1:0] steps_q;
  logic              cnt_load_q;
  logic              cnt_up_down_q;
  logic              cnt_en_q;
  logic [WIDTH-1:0]  cnt_din_q;
  logic              busy_q;
  logic              done_q;
  logic [ID_W-1:0]   done_id_q;
  logic [WIDTH-1:0]  done_count_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   rr_ptr_d;
  logic              win_load;
  logic              win_dir;
  logic [WIDTH-1:0]  win_din;
  logic [STEP_W-1:0] win_steps;

  // Walk downward so the candidate closest to rr_ptr is the last to overwrite.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign rr_ptr_d  = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign win_load  = bus.req_load[grant_idx];
  assign win_dir   = bus.req_up_down[grant_idx];
  assign win_din   = bus.req_din[int'(grant_idx) * WIDTH +: WIDTH];
  assign win_steps = bus.req_steps[int'(grant_idx) * STEP_W +: STEP_W];

  always_comb begin
    bus.req_ready = '0;
    if (!rst && state_q == S_IDLE && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      steps_q       <= '0;
      cnt_load_q    <= 1'b0;
      cnt_up_down_q <= 1'b0;
      cnt_en_q      <= 1'b0;
      cnt_din_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
      done_count_q  <= '0;
    end else begin
      cnt_load_q <= 1'b0;
      cnt_en_q   <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            id_q          <= grant_idx;
            rr_ptr_q      <= rr_ptr_d;
            cnt_up_down_q <= win_dir;
            cnt_din_q     <= win_din;
            steps_q       <= win_steps;
            busy_q        <= 1'b1;
            if (win_load) begin
              state_q    <= S_LOAD;
              cnt_load_q <= 1'b1;
            end else if (win_steps != '0) begin
              state_q  <= S_RUN;
              cnt_en_q <= 1'b1;
            end else begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              done_id_q <= grant_idx;
            end
          end
        end
        S_LOAD: begin
          if (steps_q != '0) begin
            state_q  <= S_RUN;
            cnt_en_q <= 1'b1;
          end else begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            done_id_q <= id_q;
          end
        end
        S_RUN: begin
          steps_q <= steps_q - 1'b1;
          if (steps_q == STEP_W'(1)) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            done_id_q <= id_q;
          end else begin
            cnt_en_q <= 1'b1;
          end
        end
        S_DONE: begin
          done_count_q <= bus.cnt_count;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_load    = cnt_load_q;
  assign bus.cnt_up_down = cnt_up_down_q;
  assign bus.cnt_en      = cnt_en_q;
  assign bus.cnt_din     = cnt_din_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
  // The counter settles on the edge entering DONE, so report it live in DONE.
  assign bus.done_count  = (state_q == S_DONE) ? bus.cnt_count : done_count_q;
endmodule

// File: tb/tb_count_seq_arbiter.sv
// Directed bench for count_seq_arbiter driving a simple wrapping counter model.
module tb_count_seq_arbiter;
  logic clk;
  logic rst;
  logic [3:0] cnt_q;
  int checks;
  int errors;

  count_seq_arbiter_if #(.NREQ(2), .WIDTH(4), .STEP_W(4)) bus ();

  count_seq_arbiter #(.NREQ(2), .WIDTH(4), .STEP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter the arbiter drives; wraps modulo 16.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 4'd0;
    else if (bus.cnt_load) cnt_q <= bus.cnt_din;
    else if (bus.cnt_en) cnt_q <= bus.cnt_up_down ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end
  assign bus.cnt_count = cnt_q;

  task automatic set_req(input int i, input logic ld, input logic dir,
                         input logic [3:0] din, input logic [3:0] steps);
    bus.req_load[i]          = ld;
    bus.req_up_down[i]       = dir;
    bus.req_din[i*4 +: 4]    = din;
    bus.req_steps[i*4 +: 4]  = steps;
  endtask

  task automatic wait_done(input int limit, output int cyc, output int en_n,
                           output int ld_n, output bit ok);
    cyc = 0; en_n = 0; ld_n = 0; ok = 1'b0;
    while (!ok && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (bus.cnt_en) en_n++;
      if (bus.cnt_load) ld_n++;
      if (bus.done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_load = '0; bus.req_up_down = '0; bus.req_din = '0; bus.req_steps = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", bus.req_ready); end
    checks++;
    if ({bus.busy, bus.done, bus.cnt_load, bus.cnt_en, bus.cnt_up_down} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {bus.busy, bus.done, bus.cnt_load, bus.cnt_en, bus.cnt_up_down});
    end
    checks++;
    if ({bus.cnt_din, bus.done_id, bus.done_count} !== 9'b0) begin
      errors++; $display("FAIL reset_data got %h exp 000", {bus.cnt_din, bus.done_id, bus.done_count});
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 4'd3, 4'd5);
    bus.req_valid = 2'b01;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cnt_en !== 1'b1) begin errors++; $display("FAIL midrun_en got %b exp 1", bus.cnt_en); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.cnt_load, bus.cnt_en, bus.cnt_up_down, bus.cnt_din} !== 9'b0) begin
      errors++; $display("FAIL midrun_rst_outputs got %b exp 0", {bus.busy, bus.done, bus.cnt_load, bus.cnt_en, bus.cnt_up_down, bus.cnt_din});
    end
    repeat (2) begin @(negedge clk); if (bus.done) done_seen++; end
    rst = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.done) done_seen++; end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL midrun_no_done got %0d exp 0", done_seen); end
    set_req(0, 1'b1, 1'b1, 4'd9, 4'd0);
    set_req(1, 1'b1, 1'b1, 4'd4, 4'd0);
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL midrun_ptr_reset got %b exp 01", bus.req_ready); end
    bus.req_valid = 2'b01;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    begin
      int cyc, en_n, ld_n; bit ok;
      wait_done(10, cyc, en_n, ld_n, ok);
      checks++;
      if (!ok || cyc != 2 || bus.done_count !== 4'd9) begin
        errors++; $display("FAIL midrun_after got cyc %0d cnt %0d exp cyc 2 cnt 9", cyc, bus.done_count);
      end
    end
  endtask

  task automatic test_zero_steps();
    int cyc, en_n, ld_n; bit ok;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 4'd7, 4'd0);
    bus.req_valid = 2'b01;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    wait_done(10, cyc, en_n, ld_n, ok);
    checks++;
    if (!ok || bus.done_count !== 4'd7) begin errors++; $display("FAIL preset7 got %0d exp 7", bus.done_count); end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 4'd7, 4'd0);
    bus.req_valid = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL zero_ready got %b exp 01", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 2'b00;
    wait_done(10, cyc, en_n, ld_n, ok);
    checks++;
    if (!ok || cyc != 1) begin errors++; $display("FAIL zero_latency got %0d exp 1", cyc); end
    checks++;
    if (en_n != 0 || ld_n != 0) begin errors++; $display("FAIL zero_no_en got en %0d ld %0d exp 0 0", en_n, ld_n); end
    checks++;
    if (bus.done_count !== 4'd7 || bus.done_id !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL zero_report got cnt %0d id %0d busy %0d exp 7 0 1", bus.done_count, bus.done_id, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.done_count !== 4'd7 || bus.cnt_up_down !== 1'b0) begin
      errors++; $display("FAIL zero_hold got done %0d busy %0d cnt %0d dir %0d exp 0 0 7 0", bus.done, bus.busy, bus.done_count, bus.cnt_up_down);
    end
  endtask

  task automatic test_single_req1();
    int cyc, en_n, ld_n; bit ok;
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 4'd14, 4'd3);
    bus.req_valid = 2'b10;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL req1_ready got %b exp 10", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 2'b00;
    wait_done(20, cyc, en_n, ld_n, ok);
    checks++;
    if (!ok || cyc != 5) begin errors++; $display("FAIL req1_latency got %0d exp 5", cyc); end
    checks++;
    if (ld_n != 1 || en_n != 3) begin errors++; $display("FAIL req1_phases got ld %0d en %0d exp 1 3", ld_n, en_n); end
    checks++;
    if (bus.done_id !== 1'b1 || bus.done_count !== 4'd1) begin
      errors++; $display("FAIL req1_report got id %0d cnt %0d exp 1 1", bus.done_id, bus.done_count);
    end
  endtask

  task automatic test_fairness();
    int g_idx[4]; int g_t[4]; int d_cnt[4]; int d_t[4]; int ng; int nd;
    ng = 0; nd = 0;
    for (int k = 0; k < 4; k++) begin g_idx[k] = -1; g_t[k] = -1; d_cnt[k] = -1; d_t[k] = -1; end
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 4'd0, 4'd1);
    set_req(1, 1'b1, 1'b1, 4'd1, 4'd1);
    bus.req_valid = 2'b11;
    for (int t = 0; t < 16; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (bus.req_ready != 2'b00 && ng < 4) begin g_idx[ng] = bus.req_ready[1] ? 1 : 0; g_t[ng] = t; ng++; end
      if (bus.done && nd < 4) begin d_cnt[nd] = int'(bus.done_count); d_t[nd] = t; nd++; end
    end
    bus.req_valid = 2'b00;
    checks++;
    if (ng != 4 || nd != 4) begin errors++; $display("FAIL rr_counts got grants %0d dones %0d exp 4 4", ng, nd); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (g_idx[k] != k % 2 || d_cnt[k] != 1 + k % 2) begin
        errors++; $display("FAIL rr_order[%0d] got grant %0d cnt %0d exp %0d %0d", k, g_idx[k], d_cnt[k], k % 2, 1 + k % 2);
      end
      checks++;
      if (d_t[k] != g_t[k] + 3) begin errors++; $display("FAIL rr_latency[%0d] got %0d exp %0d", k, d_t[k] - g_t[k], 3); end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (g_t[k+1] != d_t[k] + 1) begin errors++; $display("FAIL rr_gap[%0d] got %0d exp 1", k, g_t[k+1] - d_t[k]); end
    end
    @(negedge clk);
  endtask

  task automatic test_wait_while_busy();
    int cyc, en_n, ld_n; bit ok;
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 4'd2, 4'd4);
    bus.req_valid = 2'b10;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      #1;
      if (t <= 6) begin
        checks++;
        if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL busy_no_grant t%0d got %b exp 00", t, bus.req_ready); end
      end
      if (t == 6) begin
        checks++;
        if (bus.done !== 1'b1 || bus.done_id !== 1'b1 || bus.done_count !== 4'd6) begin
          errors++; $display("FAIL busy_req1_done got done %0d id %0d cnt %0d exp 1 1 6", bus.done, bus.done_id, bus.done_count);
        end
      end
      if (t == 7) begin
        checks++;
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL busy_late_grant got %b exp 01", bus.req_ready); end
      end
      if (t == 3) begin
        set_req(0, 1'b1, 1'b0, 4'd11, 4'd2);
        bus.req_valid = 2'b01;
      end
    end
    @(posedge clk); #1 bus.req_valid = 2'b00;
    wait_done(20, cyc, en_n, ld_n, ok);
    checks++;
    if (!ok || cyc != 4 || bus.done_id !== 1'b0 || bus.done_count !== 4'd9) begin
      errors++; $display("FAIL busy_req0_done got cyc %0d id %0d cnt %0d exp 4 0 9", cyc, bus.done_id, bus.done_count);
    end
  endtask

  task automatic test_long_down();
    int cyc, en_n, ld_n; bit ok;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 4'd0, 4'd15);
    bus.req_valid = 2'b01;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    wait_done(40, cyc, en_n, ld_n, ok);
    checks++;
    if (!ok || cyc != 17) begin errors++; $display("FAIL long_latency got %0d exp 17", cyc); end
    checks++;
    if (en_n != 15 || bus.done_count !== 4'd1) begin
      errors++; $display("FAIL long_result got en %0d cnt %0d exp 15 1", en_n, bus.done_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_run();
    test_zero_steps();
    test_single_req1();
    test_fairness();
    test_wait_while_busy();
    test_long_down();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
